// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding and coin values for the vending controller
package vend_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;
  localparam int V_NICKEL  = 1;
  localparam int V_DIME    = 2;
  localparam int V_QUARTER = 5;
  localparam int V_DOLLAR  = 20;
endpackage

// File: rtl/vend_change_gen.sv
// vend_change_gen: greedy change decoder, largest coin that fits the credit
module vend_change_gen import vend_pkg::*; #(
  parameter int W = 6
) (
  input  logic [W-1:0] i_credit,
  output logic         o_quarter,
  output logic         o_dime,
  output logic         o_nickel,
  output logic [2:0]   o_dec
);
  assign o_quarter = i_credit >= W'(V_QUARTER);
  assign o_dime    = !o_quarter && i_credit >= W'(V_DIME);
  assign o_nickel  = !o_quarter && !o_dime;
  assign o_dec     = o_quarter ? 3'(V_QUARTER) : o_dime ? 3'(V_DIME) : 3'(V_NICKEL);
endmodule

// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-coin vending controller with vend pulse and serial change return
module vending_machine_multi import vend_pkg::*; #(
  parameter int PRICE    = 15,
  parameter int CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                dollar,
  input  logic                cancel,
  output logic                dispense,
  output logic                chg_nickel,
  output logic                chg_dime,
  output logic                chg_quarter,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);
  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_reject;
  logic                w_q, w_d, w_n;
  logic [2:0]          w_dec;
  logic [2:0]          w_cnt;
  logic                w_coin, w_open, w_valid;
  logic [CREDIT_W:0]   w_value, w_sum;
  logic [CREDIT_W-1:0] w_left;
  vend_change_gen #(.W(CREDIT_W)) u_chg (
    .i_credit (r_credit),
    .o_quarter(w_q),
    .o_dime   (w_d),
    .o_nickel (w_n),
    .o_dec    (w_dec)
  );
  assign w_cnt   = {2'b0, nickel} + {2'b0, dime} + {2'b0, quarter} + {2'b0, dollar};
  assign w_coin  = w_cnt != 3'd0;
  assign w_open  = r_state == IDLE || r_state == COLLECT;
  assign w_valid = w_cnt == 3'd1 && w_open && !cancel;
  assign w_value = dollar  ? (CREDIT_W+1)'(V_DOLLAR)  :
                   quarter ? (CREDIT_W+1)'(V_QUARTER) :
                   dime    ? (CREDIT_W+1)'(V_DIME)    : (CREDIT_W+1)'(V_NICKEL);
  assign w_sum   = {1'b0, r_credit} + w_value;
  assign w_left  = r_credit - CREDIT_W'(w_dec);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_credit <= '0;
      r_reject <= 1'b0;
    end else begin
      r_reject <= w_coin && !w_valid;
      case (r_state)
        IDLE, COLLECT: begin
          if (w_valid) begin
            r_state  <= w_sum >= (CREDIT_W+1)'(PRICE) ? DISPENSE : COLLECT;
            r_credit <= w_sum >= (CREDIT_W+1)'(PRICE) ? CREDIT_W'(w_sum - (CREDIT_W+1)'(PRICE)) : CREDIT_W'(w_sum);
          end else if (cancel && r_state == COLLECT) r_state <= CHANGE;
        end
        DISPENSE: r_state <= r_credit != '0 ? CHANGE : IDLE;
        CHANGE: begin
          r_credit <= w_left;
          if (w_left == '0) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // outputs decode purely from registered state so no input reaches an output combinationally
  assign dispense    = r_state == DISPENSE;
  assign busy        = r_state == DISPENSE || r_state == CHANGE;
  assign chg_quarter = r_state == CHANGE && w_q;
  assign chg_dime    = r_state == CHANGE && w_d;
  assign chg_nickel  = r_state == CHANGE && w_n;
  assign coin_reject = r_reject;
  assign credit      = r_credit;
endmodule
